layer_priority_ctrl: RTL
========================

# layer_priority_ctrl

Frame-synchronous priority scheduler for the VGA object layers: takes per-layer drawing requests and RGB values, picks one visible layer per pixel from a programmable priority table, and drives the final registered pixel colour to the VGA output stage. Priority and enable changes are written into a shadow table by the game logic at any time and committed atomically at the start of each frame, so layer order never changes mid-frame. Optional per-layer blink timer hides a layer on alternate frames, for example after a hit.

## Interface
- NUM_LAYERS, 6, number of object layers; 2..8
- COLOR_W, 8, pixel colour width
- BLINK_FRAMES, 8, blink duration in frames; even, 2..15
- clk  in  1  pixel clock
- resetN  in  1  synchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- drawReq  in  NUM_LAYERS  per-layer drawing request; bit i = layer i
- layerRGB  in  NUM_LAYERS*COLOR_W  layer i colour in bits [i*COLOR_W +: COLOR_W]
- bgRGB  in  COLOR_W  background colour, used when no layer wins
- cfgValid  in  1  configuration write request
- cfgReady  out  1  write accepted when cfgValid && cfgReady
- cfgSlot  in  3  priority slot to write; slot 0 is highest priority
- cfgLayer  in  3  layer index placed in cfgSlot
- cfgEnable  in  1  enable bit for cfgLayer
- blinkReq  in  NUM_LAYERS  one-cycle pulse per layer that starts a blink
- RGBOut  out  COLOR_W  registered output pixel
- winner  out  3  index of the displayed layer; 0 when winnerValid = 0
- winnerValid  out  1  1 when a layer, not bgRGB, is displayed
- cfgPending  out  1  shadow table differs from the active table; waits for commit

## Operation
- Tables: shadow and active copies of prio[0..NUM_LAYERS-1] (3-bit layer index) and en[0..NUM_LAYERS-1].
- Reset value of both copies: prio[i] = i, en[i] = 1.
- Write, on handshake: shadow prio[cfgSlot] <= cfgLayer and shadow en[cfgLayer] <= cfgEnable; sets cfgPending.
- If cfgSlot >= NUM_LAYERS or cfgLayer >= NUM_LAYERS, the write is accepted and discarded; cfgPending is unchanged.
- cfgReady = resetN && !startOfFrame. A write presented during a commit cycle stalls one cycle.
- Commit: on startOfFrame, active <= shadow and cfgPending <= 0, whether or not the tables differ.
- Duplicate layers in the table are legal: the lowest slot decides. A layer absent from the table is never drawn.
- Masked request for layer i: drawReq[i] && active en[i] && !hide[i].
- Winner: the lowest slot s whose prio[s] has a masked request.
  - If found: winner = prio[s], RGB = that layer's colour.
  - If none: winnerValid = 0, RGB = bgRGB.
- Blink: each layer has a 4-bit counter bc[i], reset 0; hide[i] = bc[i][0].
  - blinkReq[i] loads bc[i] <= BLINK_FRAMES.
  - startOfFrame decrements every nonzero bc[i].
  - blinkReq and startOfFrame in the same cycle: the load wins and that layer is not decremented.
  - Result: frames alternate visible, hidden, ... then end visible.

## Timing
- Two-stage pipeline; latency is 2 cycles.
  - Stage 1 registers winner, valid and the selected RGB.
  - Stage 2 registers RGBOut, winner and winnerValid, all aligned.
  - Inputs sampled at cycle t appear on the outputs at t+2.
- Table commit: startOfFrame at cycle t changes the active table from cycle t+1. The pixel sampled at t uses the old table.
- Blink counter updates follow the same rule: the new hide[] value takes effect from cycle t+1.
- Sustained throughput: one pixel per cycle with no stalls. The pixel path never waits on configuration.
- While resetN = 0, sampled at a clk edge, all of the following are held at 0 on the next edge: RGBOut, winner, winnerValid, cfgPending, cfgReady, and both pipeline stages.
  - Tables and blink counters also return to their reset values.
- Reset in mid-frame or mid-write flushes the pipeline; no write is half-applied.
- Two pipeline cycles after reset release, the outputs carry valid pixels.

## Configuration
- LAYER_BLINK_EN defined:
  - blink counters are compiled in as described above.
- LAYER_BLINK_EN undefined:
  - no counters are built, blinkReq is ignored, and hide[i] = 0 permanently.
  - All other behaviour is identical.

## Test plan
- Default priority: after reset, drawReq = 6'b000110, layerRGB[1] = 8'h1C, layerRGB[2] = 8'hE0 → two cycles later RGBOut = 8'h1C, winner = 1, winnerValid = 1. With drawReq = 0 and bgRGB = 8'h25 → RGBOut = 8'h25, winnerValid = 0.
- Shadowed write: mid-frame write of slot 0 = layer 2 → cfgPending = 1 and the output is still layer 1. After startOfFrame, from t+1 the pixel is layer 2 (8'hE0) and cfgPending = 0.
- Collision: cfgValid held high across a startOfFrame pulse → cfgReady = 0 for exactly that cycle and the write is accepted the next cycle. Out-of-range write with cfgSlot = 7 → the table is unchanged and cfgPending stays 0.
- Disable: write en[1] = 0, then commit, with drawReq = 6'b000110 → layer 2 is displayed. With drawReq = 6'b000010 → bgRGB is displayed.
- Blink (LAYER_BLINK_EN): blinkReq[1] with BLINK_FRAMES = 8 and drawReq[1] held high.
  - Visibility over the next 9 frames: visible, hidden, visible, hidden, ..., visible; after that always visible.
  - blinkReq coinciding with startOfFrame → bc = 8, not 7.
  - Without the macro → layer 1 is always visible.
- Reset mid-frame: resetN low for 1 cycle after committing a non-default table → next edge RGBOut = 0 and winnerValid = 0. After release, the default order prio[i] = i is used.

Source files
------------

// File: rtl/layer_priority_ctrl_if.sv
// Pixel, configuration and blink signal bundle for layer_priority_ctrl.
// The slave modport is the scheduler side; the master modport is the driver side.
interface layer_priority_ctrl_if #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned COLOR_W    = 8
);
  logic                            startOfFrame;
  logic [NUM_LAYERS-1:0]           drawReq;
  logic [NUM_LAYERS*COLOR_W-1:0]   layerRGB;
  logic [COLOR_W-1:0]              bgRGB;
  logic                            cfgValid;
  logic                            cfgReady;
  logic [2:0]                      cfgSlot;
  logic [2:0]                      cfgLayer;
  logic                            cfgEnable;
  logic [NUM_LAYERS-1:0]           blinkReq;
  logic [COLOR_W-1:0]              RGBOut;
  logic [2:0]                      winner;
  logic                            winnerValid;
  logic                            cfgPending;

  modport slave (
    input  startOfFrame, drawReq, layerRGB, bgRGB, cfgValid, cfgSlot, cfgLayer, cfgEnable,
    input  blinkReq,
    output cfgReady, RGBOut, winner, winnerValid, cfgPending
  );

  modport master (
    output startOfFrame, drawReq, layerRGB, bgRGB, cfgValid, cfgSlot, cfgLayer, cfgEnable,
    output blinkReq,
    input  cfgReady, RGBOut, winner, winnerValid, cfgPending
  );
endinterface

// File: rtl/layer_priority_ctrl.sv
// Frame-synchronous layer priority scheduler with shadow/active tables and a 2-stage pixel path.
// Optional per-layer blink counters are compiled in when LAYER_BLINK_EN is defined.
module layer_priority_ctrl #(
  parameter int unsigned NUM_LAYERS   = 6,
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  layer_priority_ctrl_if.slave    bus
);

  localparam int unsigned IdxW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [2:0]            r_prio_sh  [NUM_LAYERS];
  logic [2:0]            r_prio_act [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_en_sh;
  logic [NUM_LAYERS-1:0] r_en_act;
  logic                  r_pending;

  logic                  w_cfg_fire;
  logic                  w_cfg_in_range;
  logic [NUM_LAYERS-1:0] w_hide;
  logic [7:0]            w_masked;
  logic [2:0]            w_win;
  logic                  w_valid;
  logic [COLOR_W-1:0]    w_rgb;

  logic [2:0]            r_s1_win;
  logic                  r_s1_valid;
  logic [COLOR_W-1:0]    r_s1_rgb;
  logic [2:0]            r_s2_win;
  logic                  r_s2_valid;
  logic [COLOR_W-1:0]    r_s2_rgb;

  // Writes stall during the commit cycle so shadow and active never update together.
  assign bus.cfgReady   = resetN && !bus.startOfFrame;
  assign w_cfg_fire     = bus.cfgValid && bus.cfgReady;
  assign w_cfg_in_range = (32'(bus.cfgSlot) < NUM_LAYERS) && (32'(bus.cfgLayer) < NUM_LAYERS);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        r_prio_sh[i]  <= 3'(i);
        r_prio_act[i] <= 3'(i);
      end
      r_en_sh   <= '1;
      r_en_act  <= '1;
      r_pending <= 1'b0;
    end else begin
      if (w_cfg_fire && w_cfg_in_range) begin
        r_prio_sh[bus.cfgSlot[IdxW-1:0]] <= bus.cfgLayer;
        r_en_sh[bus.cfgLayer[IdxW-1:0]]  <= bus.cfgEnable;
      end
      if (bus.startOfFrame) begin
        r_prio_act <= r_prio_sh;
        r_en_act   <= r_en_sh;
        r_pending  <= 1'b0;
      end else if (w_cfg_fire && w_cfg_in_range) begin
        r_pending  <= 1'b1;
      end
    end
  end

`ifdef LAYER_BLINK_EN
  logic [3:0] r_bc [NUM_LAYERS];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) r_bc[i] <= 4'd0;
    end else begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        // A fresh blink request overrides the frame decrement.
        if (bus.blinkReq[i]) begin
          r_bc[i] <= 4'(BLINK_FRAMES);
        end else if (bus.startOfFrame && (r_bc[i] != 4'd0)) begin
          r_bc[i] <= r_bc[i] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_hide = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) w_hide[i] = r_bc[i][0];
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^bus.blinkReq;
  assign w_hide         = '0;
`endif

  // Scan from the lowest-priority slot upward so the lowest matching slot wins.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      w_masked[i] = bus.drawReq[i] && r_en_act[i] && !w_hide[i];
    end
    w_win   = 3'd0;
    w_valid = 1'b0;
    w_rgb   = bus.bgRGB;
    for (int s = int'(NUM_LAYERS) - 1; s >= 0; s--) begin
      if (w_masked[r_prio_act[s]]) begin
        w_win   = r_prio_act[s];
        w_valid = 1'b1;
        w_rgb   = bus.layerRGB[int'(r_prio_act[s]) * int'(COLOR_W) +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_s1_win   <= 3'd0;
      r_s1_valid <= 1'b0;
      r_s1_rgb   <= '0;
      r_s2_win   <= 3'd0;
      r_s2_valid <= 1'b0;
      r_s2_rgb   <= '0;
    end else begin
      r_s1_win   <= w_win;
      r_s1_valid <= w_valid;
      r_s1_rgb   <= w_rgb;
      r_s2_win   <= r_s1_win;
      r_s2_valid <= r_s1_valid;
      r_s2_rgb   <= r_s1_rgb;
    end
  end

  assign bus.RGBOut      = r_s2_rgb;
  assign bus.winner      = r_s2_win;
  assign bus.winnerValid = r_s2_valid;
  assign bus.cfgPending  = r_pending;

endmodule
